bus_timer_slave: RTL
====================

Name: bus_timer_slave

Overview:
- Bus responder (slave) for the dcpu memory bus: accepts cs/we/addr/dat transactions from the CPU master and answers with registered read data plus a one-cycle ack.
- Sits beside the UART slave in the top-level address decode.
- Implements a 16-bit programmable down-counter timer with auto-reload and an interrupt that feeds the CPU irq line.

Parameters:
- WAIT_STATES, 0: extra cycles inserted between accepting a transaction and asserting o_ack (0..15).
- PRESCALE, 1: i_clk cycles per timer tick (1..65535); 1 means tick every cycle.

Ports:
- i_clk  in  1  system clock, all logic on the rising edge.
- i_reset_n  in  1  asynchronous reset, active low.
- i_cs  in  1  slave select from the top-level decode.
- i_we  in  1  1 = write, 0 = read; qualified by i_cs.
- i_addr  in  2  register select: 0 CTRL, 1 RELOAD, 2 COUNT, 3 STATUS.
- i_dat  in  16  write data.
- o_dat  out  16  read data; valid only while o_ack = 1, 0 otherwise.
- o_ack  out  1  one-cycle transaction-complete strobe.
- o_irq  out  1  level interrupt: STATUS.expired & CTRL.irq_en.
- o_reset  out  1  watchdog system-reset request (see Optional Feature).

Behaviour:
- Reset (i_reset_n low, async) state: o_dat=0, o_ack=0, o_irq=0, o_reset=0, CTRL=0, RELOAD=0xFFFF, COUNT=0, STATUS=0, prescaler=0, FSM=IDLE. Reset asserted mid-transaction aborts it; no ack is issued.
- Bus FSM states: IDLE, WAIT, ACK.
  - IDLE: when i_cs=1, latch we/addr/dat.
    - WAIT_STATES=0: go to ACK.
    - Otherwise: load the wait counter with WAIT_STATES-1 and go to WAIT.
  - WAIT: decrement the wait counter; go to ACK when it reaches 0.
  - ACK: o_ack=1 for exactly one cycle.
    - Write: the register update takes effect at the end of this cycle.
    - Read: o_dat holds the register value sampled on ACK entry.
    - Next state is IDLE. i_cs is ignored while in WAIT and ACK.
  - Latency from i_cs sampled to o_ack is 1+WAIT_STATES cycles. Back-to-back i_cs gives at most one ack every 2+WAIT_STATES cycles.
- CTRL register:
  - bit0 en, bit1 auto_reload, bit2 irq_en, bit3 wdt; bits 15:4 read 0.
  - A write that sets en from 0 to 1 clears the prescaler.
- Prescaler: counts 0..PRESCALE-1 while en=1. tick=1 on the wrap cycle; with PRESCALE=1, tick=1 every enabled cycle.
- Counter, on a tick:
  - COUNT != 0: COUNT -= 1.
  - COUNT == 0: STATUS.expired <= 1. If auto_reload, COUNT <= RELOAD; otherwise CTRL.en <= 0 and COUNT stays 0.
- STATUS register: bit0 expired. Writing 1 to bit0 clears it; writing 0 has no effect.
- Simultaneous events:
  - Bus write to COUNT and a tick in the same cycle: the bus write wins and no decrement occurs.
  - STATUS clear and expiry in the same cycle: expiry wins and expired stays 1.
  - Bus write to CTRL.en=0 and expiry in the same cycle: the bus write wins.
- Arithmetic: all counter arithmetic is 16-bit unsigned with no wrap below 0; the zero case is handled as described under Counter.

Optional Feature:
- Macro: BUS_TIMER_WDT_EN.
- With the macro:
  - CTRL.wdt is implemented.
  - Expiry with wdt=1 asserts o_reset for exactly 4 cycles.
  - It also clears CTRL.en regardless of auto_reload.
  - A further expiry during the pulse restarts the 4-cycle pulse.
- Without the macro:
  - CTRL.wdt is not stored and reads 0.
  - o_reset is tied 0.
  - No pulse counter is present.

Decomposition:
- Shared package (dcpu_bus_pkg):
  - Register address constants: ADDR_CTRL=0, ADDR_RELOAD=1, ADDR_COUNT=2, ADDR_STATUS=3.
  - CTRL bit indices.
  - Bus FSM state encoding (IDLE/WAIT/ACK), reused by future bus slaves.
- One natural sub-module: bus_slave_if, holding the IDLE/WAIT/ACK FSM, wait counter and request latch. It outputs a one-cycle req_strobe with latched we/addr/dat to the timer core.

Test Plan:
- Reset and registers, WAIT_STATES=0: after reset, read RELOAD -> o_ack exactly 1 cycle after i_cs, o_dat=0xFFFF. Read COUNT -> 0x0000.
- Wait states, WAIT_STATES=3: write RELOAD=0x1234 -> o_ack 4 cycles after i_cs. Read back -> 0x1234. o_dat=0 in every non-ack cycle.
- One-shot, PRESCALE=1: write COUNT=5, then CTRL=0x5 (en, irq_en) -> expired and o_irq rise 6 cycles after en is set. en then reads 0 and COUNT holds 0. Write STATUS=1 -> o_irq falls.
- Auto-reload, PRESCALE=4: RELOAD=2, COUNT=2, CTRL=0x3 -> expiry every 12 cycles, repeated 3 times with no software intervention.
- Collisions:
  - COUNT write (0x0100) coinciding with a tick -> COUNT reads 0x0100.
  - STATUS clear coinciding with expiry -> expired reads 1.
  - Reset pulsed during WAIT -> no o_ack and all registers at reset values.
- Watchdog (BUS_TIMER_WDT_EN): COUNT=3, CTRL=0x9 -> o_reset high for exactly 4 cycles starting at expiry, en cleared. Without the macro, o_reset stays 0 and CTRL reads 0x1.

Source files
------------

// File: rtl/dcpu_bus_pkg.sv
// dcpu_bus_pkg: definitions shared by dcpu memory-bus slaves.
//   - register address map of the bus timer (CTRL/RELOAD/COUNT/STATUS)
//   - CTRL register bit positions
//   - bus handshake FSM state encoding (IDLE/WAIT/ACK), common to all slaves
// No ports; import with "import dcpu_bus_pkg::*;".
package dcpu_bus_pkg;

  // Timer register map (2-bit word address)
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_RELOAD = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  // CTRL bit positions
  localparam int CTRL_EN          = 0;
  localparam int CTRL_AUTO_RELOAD = 1;
  localparam int CTRL_IRQ_EN      = 2;
  localparam int CTRL_WDT         = 3;

  // STATUS bit positions
  localparam int STATUS_EXPIRED = 0;

  // Reset value of the RELOAD register
  localparam logic [15:0] RELOAD_RESET = 16'hFFFF;

  // Length of the watchdog reset request, in clock cycles
  localparam int WDT_PULSE_CYCLES = 4;

  // Bus slave handshake FSM
  typedef enum logic [1:0] {
    BUS_IDLE = 2'd0,
    BUS_WAIT = 2'd1,
    BUS_ACK  = 2'd2
  } bus_state_t;

endpackage

// File: rtl/bus_slave_if.sv
// bus_slave_if: generic dcpu bus handshake for a register slave.
// Accepts a transaction in IDLE, optionally burns WAIT_STATES cycles in
// WAIT, then spends exactly one cycle in ACK. i_cs is ignored outside IDLE.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cs, we, addr, dat   bus request from the master
//   req_strobe          high for the single ACK cycle (drives the bus ack)
//   req_we/addr/dat     request latched when it was accepted
//   rdata_load          high in the cycle before ACK: capture read data now
//   rdata_addr          register address to capture read data from
module bus_slave_if
  import dcpu_bus_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [15:0] dat,
  output logic        req_strobe,
  output logic        req_we,
  output logic [1:0]  req_addr,
  output logic [15:0] req_dat,
  output logic        rdata_load,
  output logic [1:0]  rdata_addr
);

  // WAIT holds for WAIT_LOAD+1 cycles, so ACK follows acceptance by
  // 1+WAIT_STATES cycles.
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  bus_state_t state_reg, state_next;
  logic [3:0] wait_cnt_reg;
  logic       accept;

  assign accept = (state_reg == BUS_IDLE) && cs;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= BUS_IDLE;
    else        state_reg <= state_next;
  end

  // Request latch and wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_reg <= 4'd0;
      req_we       <= 1'b0;
      req_addr     <= 2'd0;
      req_dat      <= 16'd0;
    end else if (accept) begin
      wait_cnt_reg <= WAIT_LOAD;
      req_we       <= we;
      req_addr     <= addr;
      req_dat      <= dat;
    end else if ((state_reg == BUS_WAIT) && (wait_cnt_reg != 4'd0)) begin
      wait_cnt_reg <= wait_cnt_reg - 4'd1;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      BUS_IDLE: if (cs) state_next = (WAIT_STATES == 0) ? BUS_ACK : BUS_WAIT;
      BUS_WAIT: if (wait_cnt_reg == 4'd0) state_next = BUS_ACK;
      BUS_ACK:  state_next = BUS_IDLE;
      default:  state_next = BUS_IDLE;
    endcase
  end

  // Outputs. With no wait states the request is accepted on the same edge
  // that enters ACK, so the read address must come straight from the bus.
  always_comb begin
    req_strobe = (state_reg == BUS_ACK);
    rdata_load = (state_next == BUS_ACK);
    rdata_addr = (state_reg == BUS_IDLE) ? addr : req_addr;
  end

endmodule

// File: rtl/bus_timer_slave.sv
// bus_timer_slave: 16-bit down-counting timer on the dcpu memory bus.
// Registers: CTRL (en, auto_reload, irq_en, wdt), RELOAD, COUNT, STATUS.
// A prescaler divides the clock by PRESCALE to produce timer ticks; on a
// tick with COUNT==0 the timer expires, sets STATUS.expired, and either
// reloads or stops.
// Optional feature macro: BUS_TIMER_WDT_EN -- when defined, CTRL.wdt is
// stored and an expiry with wdt=1 raises o_reset for 4 cycles and stops the
// timer; when undefined CTRL.wdt reads 0 and o_reset is tied low.
// Ports:
//   i_clk, i_reset_n     clock, asynchronous active-low reset
//   i_cs, i_we           select and write enable from the address decode
//   i_addr, i_dat        register address and write data
//   o_dat, o_ack         read data (0 outside ack) and one-cycle ack
//   o_irq                STATUS.expired & CTRL.irq_en
//   o_reset              watchdog system-reset request
module bus_timer_slave
  import dcpu_bus_pkg::*;
#(
  parameter int WAIT_STATES = 0,
  parameter int PRESCALE    = 1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_cs,
  input  logic        i_we,
  input  logic [1:0]  i_addr,
  input  logic [15:0] i_dat,
  output logic [15:0] o_dat,
  output logic        o_ack,
  output logic        o_irq,
  output logic        o_reset
);

  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

  logic        req_strobe, req_we, rdata_load;
  logic [1:0]  req_addr, rdata_addr;
  logic [15:0] req_dat;

  bus_slave_if #(.WAIT_STATES(WAIT_STATES)) u_bus (
    .clk        (i_clk),
    .rst_n      (i_reset_n),
    .cs         (i_cs),
    .we         (i_we),
    .addr       (i_addr),
    .dat        (i_dat),
    .req_strobe (req_strobe),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_dat    (req_dat),
    .rdata_load (rdata_load),
    .rdata_addr (rdata_addr)
  );

  logic wr_ctrl, wr_reload, wr_count, wr_status;
  assign wr_ctrl   = req_strobe && req_we && (req_addr == ADDR_CTRL);
  assign wr_reload = req_strobe && req_we && (req_addr == ADDR_RELOAD);
  assign wr_count  = req_strobe && req_we && (req_addr == ADDR_COUNT);
  assign wr_status = req_strobe && req_we && (req_addr == ADDR_STATUS);

  logic        en_reg, auto_reload_reg, irq_en_reg, expired_reg, wdt_bit;
  logic [15:0] reload_reg, count_reg, pre_reg, rdata_reg, rd_mux;
  logic        tick, expire;

  assign tick   = en_reg && (pre_reg == PRE_LAST);
  assign expire = tick && (count_reg == 16'd0);

  // Prescaler restarts from 0 whenever the timer is switched on.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                                 pre_reg <= 16'd0;
    else if (wr_ctrl && req_dat[CTRL_EN] && !en_reg) pre_reg <= 16'd0;
    else if (en_reg)                                pre_reg <= tick ? 16'd0 : pre_reg + 16'd1;
  end

  // CTRL: a bus write beats an expiry that would clear en.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      en_reg          <= 1'b0;
      auto_reload_reg <= 1'b0;
      irq_en_reg      <= 1'b0;
    end else if (wr_ctrl) begin
      en_reg          <= req_dat[CTRL_EN];
      auto_reload_reg <= req_dat[CTRL_AUTO_RELOAD];
      irq_en_reg      <= req_dat[CTRL_IRQ_EN];
    end else if (expire && (!auto_reload_reg || wdt_bit)) begin
      en_reg <= 1'b0;
    end
  end

  // RELOAD
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)     reload_reg <= RELOAD_RESET;
    else if (wr_reload) reload_reg <= req_dat;
  end

  // COUNT: a bus write replaces the tick's decrement; never wraps below 0.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) count_reg <= 16'd0;
    else if (wr_count) count_reg <= req_dat;
    else if (tick) begin
      if (count_reg != 16'd0)   count_reg <= count_reg - 16'd1;
      else if (auto_reload_reg) count_reg <= reload_reg;
    end
  end

  // STATUS: expiry outranks a software clear in the same cycle.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                                    expired_reg <= 1'b0;
    else if (expire)                                   expired_reg <= 1'b1;
    else if (wr_status && req_dat[STATUS_EXPIRED])     expired_reg <= 1'b0;
  end

`ifdef BUS_TIMER_WDT_EN
  logic       wdt_reg;
  logic [2:0] pulse_cnt_reg;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)   wdt_reg <= 1'b0;
    else if (wr_ctrl) wdt_reg <= req_dat[CTRL_WDT];
  end

  // A new expiry reloads the counter, stretching an active pulse.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                   pulse_cnt_reg <= 3'd0;
    else if (expire && wdt_reg)       pulse_cnt_reg <= 3'(WDT_PULSE_CYCLES);
    else if (pulse_cnt_reg != 3'd0)   pulse_cnt_reg <= pulse_cnt_reg - 3'd1;
  end

  assign wdt_bit = wdt_reg;
  assign o_reset = (pulse_cnt_reg != 3'd0);
`else
  assign wdt_bit = 1'b0;
  assign o_reset = 1'b0;
`endif

  // Read mux, captured on the edge that enters ACK.
  always_comb begin
    rd_mux = 16'd0;
    case (rdata_addr)
      ADDR_CTRL:   rd_mux = {12'd0, wdt_bit, irq_en_reg, auto_reload_reg, en_reg};
      ADDR_RELOAD: rd_mux = reload_reg;
      ADDR_COUNT:  rd_mux = count_reg;
      ADDR_STATUS: rd_mux = {15'd0, expired_reg};
      default:     rd_mux = 16'd0;
    endcase
  end

  // Cleared every other cycle so o_dat is zero whenever o_ack is low.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) rdata_reg <= 16'd0;
    else            rdata_reg <= rdata_load ? rd_mux : 16'd0;
  end

  assign o_dat = rdata_reg;
  assign o_ack = req_strobe;
  assign o_irq = expired_reg && irq_en_reg;

endmodule
